// File: rtl/hci_package.sv
// -----------------------------------------------------------------------------
// hci_package
//   Shared types and defaults for the HCI interconnect blocks.
//   - DEFAULT_AW / DEFAULT_DW / DEFAULT_BW : default address, data and byte widths
//   - hci_arb_policy_e                     : bank arbitration policy encoding
//   - hci_interconnect_ctrl_t              : runtime control word of the interconnect
// -----------------------------------------------------------------------------
package hci_package;

  localparam int unsigned DEFAULT_AW = 32;
  localparam int unsigned DEFAULT_DW = 32;
  localparam int unsigned DEFAULT_BW = 8;

  typedef enum logic {
    HCI_ARB_RR    = 1'b0,
    HCI_ARB_FIXED = 1'b1
  } hci_arb_policy_e;

  typedef struct packed {
    hci_arb_policy_e arb_policy;
  } hci_interconnect_ctrl_t;

endpackage

// File: rtl/hci_arb_stall_counter.sv
// -----------------------------------------------------------------------------
// hci_arb_stall_counter
//   Per-requester starvation counter used by hci_l2_bank_arbiter when
//   HCI_L2_ARB_STARVATION_EN is defined. Counts cycles in which the requester
//   asks for the bank but does not complete a handshake; saturates at MAX_STALL.
// Ports:
//   clk_i     : clock (rising edge)
//   rst_i     : synchronous active-high reset, clears the counter
//   req_i     : requester is asking for the bank this cycle
//   win_hs_i  : requester is the winner of a handshake this cycle
//   starved_o : counter has reached MAX_STALL
// -----------------------------------------------------------------------------
module hci_arb_stall_counter #(
  parameter int unsigned MAX_STALL = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_i,
  input  logic win_hs_i,
  output logic starved_o
);

  localparam int unsigned CW = $clog2(MAX_STALL + 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (!req_i || win_hs_i) begin
      cnt_q <= '0;
    end else if (cnt_q != CW'(MAX_STALL)) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign starved_o = (cnt_q == CW'(MAX_STALL));

endmodule

// File: rtl/hci_l2_bank_arbiter.sv
// -----------------------------------------------------------------------------
// hci_l2_bank_arbiter
//   Shares one L2 bank port between N_IN requesters. The winner is picked
//   combinationally each cycle (round-robin from rr_q, or fixed priority with
//   the lowest index first) and its request is forwarded to the bank. The read
//   response arrives one cycle after the handshake and is routed back by the
//   one-hot id returned by the bank.
//   Optional feature macro: HCI_L2_ARB_STARVATION_EN -- per-input stall
//   counters; an input that waited MAX_STALL cycles overrides the policy.
// Ports:
//   clk_i, rst_i                     : clock, synchronous active-high reset
//   ctrl_i                           : control word, arb_policy field used
//   in_req_i/in_wen_i/in_add_i/
//   in_data_i/in_be_i                : requester side requests
//   in_gnt_o/in_r_valid_o/in_r_data_o: requester side grant and response
//   mem_req_o/mem_wen_o/mem_add_o/
//   mem_data_o/mem_be_o/mem_id_o     : bank request, id is one-hot winner
//   mem_gnt_i/mem_r_data_i/mem_r_id_i: bank grant and response
// -----------------------------------------------------------------------------
module hci_l2_bank_arbiter
  import hci_package::*;
#(
  parameter int unsigned N_IN      = 4,
  parameter int unsigned AW        = hci_package::DEFAULT_AW,
  parameter int unsigned DW        = hci_package::DEFAULT_DW,
  parameter int unsigned BW        = hci_package::DEFAULT_BW,
  parameter int unsigned IW        = N_IN,
  parameter int unsigned MAX_STALL = 8
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  hci_interconnect_ctrl_t          ctrl_i,
  input  logic [N_IN-1:0]                 in_req_i,
  input  logic [N_IN-1:0]                 in_wen_i,
  input  logic [N_IN-1:0][AW-1:0]         in_add_i,
  input  logic [N_IN-1:0][DW-1:0]         in_data_i,
  input  logic [N_IN-1:0][DW/BW-1:0]      in_be_i,
  output logic [N_IN-1:0]                 in_gnt_o,
  output logic [N_IN-1:0]                 in_r_valid_o,
  output logic [N_IN-1:0][DW-1:0]         in_r_data_o,
  output logic                            mem_req_o,
  output logic                            mem_wen_o,
  output logic [AW-1:0]                   mem_add_o,
  output logic [DW-1:0]                   mem_data_o,
  output logic [DW/BW-1:0]                mem_be_o,
  output logic [IW-1:0]                   mem_id_o,
  input  logic                            mem_gnt_i,
  input  logic [DW-1:0]                   mem_r_data_i,
  input  logic [IW-1:0]                   mem_r_id_i
);

  localparam int unsigned IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;

  logic [IDX_W-1:0] rr_q;
  logic [IDX_W-1:0] win_idx;
  logic [N_IN-1:0]  win_oh;
  logic             handshake;
  logic             r_valid_q;

  assign mem_req_o = |in_req_i;
  assign handshake = mem_req_o & mem_gnt_i;

`ifdef HCI_L2_ARB_STARVATION_EN
  logic [N_IN-1:0] starved;

  for (genvar i = 0; i < N_IN; i++) begin : g_stall
    hci_arb_stall_counter #(
      .MAX_STALL (MAX_STALL)
    ) u_stall (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .req_i     (in_req_i[i]),
      .win_hs_i  (handshake & win_oh[i]),
      .starved_o (starved[i])
    );
  end
`endif

  // Descending loops let the lowest qualifying candidate be the last write.
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    cand     = 0;
    cand_idx = '0;
    win_idx  = '0;
    if (ctrl_i.arb_policy == HCI_ARB_FIXED) begin
      for (int k = N_IN - 1; k >= 0; k--) begin
        if (in_req_i[k]) win_idx = IDX_W'(k);
      end
    end else begin
      for (int k = N_IN - 1; k >= 0; k--) begin
        cand = int'(rr_q) + k;
        if (cand >= int'(N_IN)) cand = cand - int'(N_IN);
        cand_idx = IDX_W'(cand);
        if (in_req_i[cand_idx]) win_idx = cand_idx;
      end
    end
`ifdef HCI_L2_ARB_STARVATION_EN
    // A starved requester still asking for the bank beats either policy.
    for (int k = N_IN - 1; k >= 0; k--) begin
      if (starved[k] && in_req_i[k]) win_idx = IDX_W'(k);
    end
`endif
  end

  assign win_oh     = mem_req_o ? (N_IN'(1) << win_idx) : '0;
  assign mem_id_o   = IW'(win_oh);
  assign in_gnt_o   = win_oh & {N_IN{mem_gnt_i}};
  assign mem_wen_o  = in_wen_i[win_idx];
  assign mem_add_o  = in_add_i[win_idx];
  assign mem_data_o = in_data_i[win_idx];
  assign mem_be_o   = in_be_i[win_idx];

  // Handshake boundary: pointer advance and one-cycle response tracking.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q      <= '0;
      r_valid_q <= 1'b0;
    end else begin
      r_valid_q <= handshake;
      if (handshake && (ctrl_i.arb_policy == HCI_ARB_RR)) begin
        rr_q <= (win_idx == IDX_W'(N_IN - 1)) ? '0 : win_idx + IDX_W'(1);
      end
    end
  end

  for (genvar i = 0; i < N_IN; i++) begin : g_resp
    if (i < IW) begin : g_id
      assign in_r_valid_o[i] = r_valid_q & mem_r_id_i[i];
    end else begin : g_noid
      assign in_r_valid_o[i] = 1'b0;
    end
    assign in_r_data_o[i] = mem_r_data_i;
  end

endmodule

// File: tb/tb_hci_l2_bank_arbiter.sv
module tb_hci_l2_bank_arbiter;
  import hci_package::*;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BEW = 4;
  localparam int MS = 8;

  logic                  clk = 1'b0;
  logic                  rst_i;
  hci_interconnect_ctrl_t ctrl_i;
  logic [N-1:0]          in_req_i, in_wen_i;
  logic [N-1:0][AW-1:0]  in_add_i;
  logic [N-1:0][DW-1:0]  in_data_i;
  logic [N-1:0][BEW-1:0] in_be_i;
  logic [N-1:0]          in_gnt_o, in_r_valid_o;
  logic [N-1:0][DW-1:0]  in_r_data_o;
  logic                  mem_req_o, mem_wen_o;
  logic [AW-1:0]         mem_add_o;
  logic [DW-1:0]         mem_data_o;
  logic [BEW-1:0]        mem_be_o;
  logic [N-1:0]          mem_id_o;
  logic                  mem_gnt_i;
  logic [DW-1:0]         mem_r_data_i;
  logic [N-1:0]          mem_r_id_i;

  hci_l2_bank_arbiter #(.N_IN(N), .AW(AW), .DW(DW), .BW(8), .IW(N), .MAX_STALL(MS)) dut (
    .clk_i(clk), .rst_i(rst_i), .ctrl_i(ctrl_i),
    .in_req_i(in_req_i), .in_wen_i(in_wen_i), .in_add_i(in_add_i),
    .in_data_i(in_data_i), .in_be_i(in_be_i),
    .in_gnt_o(in_gnt_o), .in_r_valid_o(in_r_valid_o), .in_r_data_o(in_r_data_o),
    .mem_req_o(mem_req_o), .mem_wen_o(mem_wen_o), .mem_add_o(mem_add_o),
    .mem_data_o(mem_data_o), .mem_be_o(mem_be_o), .mem_id_o(mem_id_o),
    .mem_gnt_i(mem_gnt_i), .mem_r_data_i(mem_r_data_i), .mem_r_id_i(mem_r_id_i)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state: priority pointer, pending response, waiting times.
  int       m_rr   = 0;
  bit       m_pend = 1'b0;
  int       m_wait [N];
  logic [N-1:0] m_rid_drive = '0;

  // Values seen at the last sample point, for hand-written sequences.
  logic [N-1:0] got_id, got_gnt, got_rv;

  typedef struct {
    logic [N-1:0] req;
    bit           pol;
    bit           gnt;
    logic [N-1:0] id;
    logic [N-1:0] g;
    logic [N-1:0] rv;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Who should own the bank: a requester that waited MAX_STALL cycles (when
  // starvation protection is built in), otherwise the policy's first choice.
  function automatic int model_winner(input logic [N-1:0] req, input bit pol);
    if (req == '0) return -1;
`ifdef HCI_L2_ARB_STARVATION_EN
    for (int i = 0; i < N; i++) if (req[i] && m_wait[i] == MS) return i;
`endif
    if (pol) begin
      for (int i = 0; i < N; i++) if (req[i]) return i;
    end else begin
      for (int k = 0; k < N; k++) if (req[(m_rr + k) % N]) return (m_rr + k) % N;
    end
    return -1;
  endfunction

  task automatic run_cycle(input logic [N-1:0] req, input bit pol, input bit gnt, input bit rst);
    int           w;
    bit           hs;
    logic [N-1:0] exp_id;
    logic [DW-1:0] rdata;
    in_req_i          = req;
    ctrl_i.arb_policy = pol ? HCI_ARB_FIXED : HCI_ARB_RR;
    mem_gnt_i         = gnt;
    rst_i             = rst;
    for (int i = 0; i < N; i++) begin
      in_add_i[i]  = $urandom;
      in_data_i[i] = $urandom;
      in_be_i[i]   = BEW'($urandom);
      in_wen_i[i]  = 1'($urandom);
    end
    rdata        = $urandom;
    mem_r_data_i = rdata;
    mem_r_id_i   = m_rid_drive;
    @(negedge clk);
    w      = model_winner(req, pol);
    exp_id = (w >= 0) ? N'(1 << w) : '0;
    got_id  = mem_id_o;
    got_gnt = in_gnt_o;
    got_rv  = in_r_valid_o;
    chk("mem_req", 32'(mem_req_o), 32'(req != '0));
    chk("mem_id", 32'(mem_id_o), 32'(exp_id));
    chk("in_gnt", 32'(in_gnt_o), 32'(gnt ? exp_id : '0));
    chk("r_valid", 32'(in_r_valid_o), 32'(m_pend ? m_rid_drive : '0));
    for (int i = 0; i < N; i++) chk("r_data", in_r_data_o[i], rdata);
    if (w >= 0) begin
      chk("mem_add", mem_add_o, in_add_i[w]);
      chk("mem_data", mem_data_o, in_data_i[w]);
      chk("mem_be", 32'(mem_be_o), 32'(in_be_i[w]));
      chk("mem_wen", 32'(mem_wen_o), 32'(in_wen_i[w]));
    end
    @(posedge clk);
    hs = (req != '0) && gnt;
    if (rst) begin
      m_rr   = 0;
      m_pend = 1'b0;
      for (int i = 0; i < N; i++) m_wait[i] = 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (!req[i] || (hs && w == i)) m_wait[i] = 0;
        else if (m_wait[i] < MS) m_wait[i] = m_wait[i] + 1;
      end
      if (hs && !pol) m_rr = (w + 1) % N;
      m_pend = hs;
    end
    m_rid_drive = hs ? exp_id : N'($urandom);
    #1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) m_wait[i] = 0;
    in_req_i = '0; in_wen_i = '0; in_add_i = '0; in_data_i = '0; in_be_i = '0;
    ctrl_i.arb_policy = HCI_ARB_RR; mem_gnt_i = 1'b0;
    mem_r_data_i = '0; mem_r_id_i = '0;
    rst_i = 1'b1;
    @(posedge clk); #1;

    // Reset state: leave reset with nothing pending.
    run_cycle(4'b0000, 1'b0, 1'b0, 1'b1);
    run_cycle(4'b0000, 1'b0, 1'b1, 1'b0);
    chk("rst_id", 32'(got_id), 32'h0);
    chk("rst_gnt", 32'(got_gnt), 32'h0);
    chk("rst_rv", 32'(got_rv), 32'h0);

    // Round-robin with all inputs and a permanent grant, then an idle cycle.
    tbl[0] = '{4'b1111, 1'b0, 1'b1, 4'b0001, 4'b0001, 4'b0000};
    tbl[1] = '{4'b1111, 1'b0, 1'b1, 4'b0010, 4'b0010, 4'b0001};
    tbl[2] = '{4'b1111, 1'b0, 1'b1, 4'b0100, 4'b0100, 4'b0010};
    tbl[3] = '{4'b1111, 1'b0, 1'b1, 4'b1000, 4'b1000, 4'b0100};
    tbl[4] = '{4'b1111, 1'b0, 1'b1, 4'b0001, 4'b0001, 4'b1000};
    tbl[5] = '{4'b1111, 1'b0, 1'b1, 4'b0010, 4'b0010, 4'b0001};
    tbl[6] = '{4'b1111, 1'b0, 1'b1, 4'b0100, 4'b0100, 4'b0010};
    tbl[7] = '{4'b1111, 1'b0, 1'b1, 4'b1000, 4'b1000, 4'b0100};
    tbl[8] = '{4'b0000, 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b1000};
    for (int t = 0; t < 9; t++) begin
      run_cycle(tbl[t].req, tbl[t].pol, tbl[t].gnt, 1'b0);
      chk($sformatf("tbl%0d_id", t), 32'(got_id), 32'(tbl[t].id));
      chk($sformatf("tbl%0d_gnt", t), 32'(got_gnt), 32'(tbl[t].g));
      chk($sformatf("tbl%0d_rv", t), 32'(got_rv), 32'(tbl[t].rv));
    end

    // Pointer at 3, lone request from input 1, then full order from 2 with wrap.
    run_cycle(4'b0000, 1'b0, 1'b0, 1'b1);
    run_cycle(4'b0100, 1'b0, 1'b1, 1'b0);
    run_cycle(4'b0010, 1'b0, 1'b1, 1'b0);
    chk("wrap_lone", 32'(got_id), 32'h2);
    run_cycle(4'b1111, 1'b0, 1'b1, 1'b0);
    chk("wrap_o0", 32'(got_id), 32'h4);
    run_cycle(4'b1111, 1'b0, 1'b1, 1'b0);
    chk("wrap_o1", 32'(got_id), 32'h8);
    run_cycle(4'b1111, 1'b0, 1'b1, 1'b0);
    chk("wrap_o2", 32'(got_id), 32'h1);
    run_cycle(4'b1111, 1'b0, 1'b1, 1'b0);
    chk("wrap_o3", 32'(got_id), 32'h2);

    // Bank stalls for three cycles, then accepts; response one cycle later.
    run_cycle(4'b0000, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      run_cycle(4'b0010, 1'b0, 1'b0, 1'b0);
      chk("stall_id", 32'(got_id), 32'h2);
      chk("stall_gnt", 32'(got_gnt), 32'h0);
      chk("stall_rv", 32'(got_rv), 32'h0);
    end
    run_cycle(4'b0010, 1'b0, 1'b1, 1'b0);
    chk("stall_hs_gnt", 32'(got_gnt), 32'h2);
    run_cycle(4'b0000, 1'b0, 1'b0, 1'b0);
    chk("stall_resp", 32'(got_rv), 32'h2);

    // Fixed priority with inputs 0 and 2 competing.
    run_cycle(4'b0000, 1'b0, 1'b0, 1'b1);
    for (int c = 1; c <= 11; c++) begin
      run_cycle(4'b0101, 1'b1, 1'b1, 1'b0);
`ifdef HCI_L2_ARB_STARVATION_EN
      chk($sformatf("fixed_c%0d", c), 32'(got_id), (c == 9) ? 32'h4 : 32'h1);
`else
      chk($sformatf("fixed_c%0d", c), 32'(got_id), 32'h1);
`endif
    end

    // Reset right after a handshake drops the response of the reset cycle.
    run_cycle(4'b0000, 1'b0, 1'b0, 1'b1);
    run_cycle(4'b0010, 1'b0, 1'b1, 1'b0);
    run_cycle(4'b0100, 1'b0, 1'b1, 1'b1);
    chk("mid_rst_rv_before", 32'(got_rv), 32'h2);
    run_cycle(4'b1111, 1'b0, 1'b1, 1'b0);
    chk("mid_rst_rv_after", 32'(got_rv), 32'h0);
    chk("mid_rst_rr0", 32'(got_id), 32'h1);

    // Random traffic against the model; second half in fixed priority.
    for (int c = 0; c < 400; c++) begin
      run_cycle(N'($urandom_range(0, 15)),
                (c >= 200) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 49) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/hci_l2_bank_arbiter.md
HCI_L2_BANK_ARBITER -- requirements
Module: hci_l2_bank_arbiter

Interface
REQ-001 SHALL have parameter N_IN, default 4: number of requesters sharing one L2 bank port.
REQ-002 SHALL have parameter AW, default hci_package::DEFAULT_AW: byte address width.
REQ-003 SHALL have parameters DW and BW, defaults hci_package::DEFAULT_DW and DEFAULT_BW: data width and byte width; BE width is DW/BW.
REQ-004 SHALL have parameter IW, default N_IN: one-hot ID width.
REQ-005 SHALL have parameter MAX_STALL, default 8: starvation threshold in cycles.
REQ-006 SHALL have the port clk_i, input, 1: the only clock; one clock domain; all state on its rising edge.
REQ-007 SHALL have the port rst_i, input, 1: reset, synchronous and active-high.
REQ-008 SHALL have the port ctrl_i, input, hci_interconnect_ctrl_t: only the arb_policy field is used (0 = round-robin, 1 = fixed priority, lowest index wins).
REQ-009 SHALL have the ports in_req_i/in_wen_i (input, N_IN), in_add_i (input, N_IN x AW), in_data_i (input, N_IN x DW), in_be_i (input, N_IN x DW/BW): requester side.
REQ-010 SHALL have the ports in_gnt_o, in_r_valid_o (output, N_IN) and in_r_data_o (output, N_IN x DW): grant, read-response valid and read data per requester.
REQ-011 SHALL have the ports mem_req_o, mem_wen_o (output, 1), mem_add_o (output, AW), mem_data_o (output, DW), mem_be_o (output, DW/BW) and mem_id_o (output, IW): bank request.
REQ-012 SHALL have the ports mem_gnt_i (input, 1), mem_r_data_i (input, DW) and mem_r_id_i (input, IW): bank grant and response.

Function
REQ-013 mem_req_o SHALL be the OR of in_req_i (combinational).
REQ-014 The winner SHALL be chosen combinationally each cycle. Its add/wen/data/be drive mem_*_o, and mem_id_o is the one-hot winner index.
REQ-015 in_gnt_o[w] SHALL equal mem_gnt_i for winner w only. All other in_gnt_o bits SHALL be 0.
REQ-016 Round-robin SHALL search from pointer rr_q upward with wrap. On handshake (mem_req_o & mem_gnt_i), rr_q <= w+1, and w = N_IN-1 wraps to 0.
REQ-017 With fixed priority, rr_q SHALL hold its value. A policy change SHALL take effect in the same cycle with no state flush.
REQ-018 No handshake SHALL mean no rr_q update, and the winner SHALL stay stable while its request is held.
REQ-019 Response valid: r_valid_q <= mem_req_o & mem_gnt_i, so the response is exactly 1 cycle after the handshake.
REQ-020 in_r_valid_o[i] SHALL equal r_valid_q & mem_r_id_i[i]. mem_r_data_i SHALL be broadcast to every in_r_data_o[i].
REQ-021 Back-to-back handshakes SHALL sustain 1 transaction per cycle.
REQ-022 No-request cycles SHALL have mem_req_o=0, mem_id_o=0 and all gnt 0. Other mem_*_o values are don't-care.

Reset
REQ-023 While rst_i=1 at a clock edge: rr_q <= 0, r_valid_q <= 0 and stall counters <= 0. In the next cycle in_r_valid_o SHALL be 0.
REQ-024 Reset asserted mid-transaction SHALL drop any pending response, with no in_r_valid_o in the following cycle. Combinational outputs SHALL follow the inputs.

Configuration
REQ-025 Macro HCI_L2_ARB_STARVATION_EN SHALL control starvation protection.
REQ-026 When HCI_L2_ARB_STARVATION_EN is defined:
  - each input has a saturating counter, $clog2(MAX_STALL+1) bits;
  - the counter increments when in_req_i=1 and the input is not the handshake winner;
  - it clears on handshake or when the request drops;
  - the lowest-index input with counter = MAX_STALL overrides the policy as winner.
REQ-027 When HCI_L2_ARB_STARVATION_EN is undefined, there SHALL be no counters and no override. Behaviour is exactly REQ-016/017.

Structure
REQ-028 hci_package SHALL add typedef hci_arb_policy_e (HCI_ARB_RR=0, HCI_ARB_FIXED=1). ctrl_i.arb_policy SHALL be compared against it.
REQ-029 Starvation counters SHALL live in sub-module hci_arb_stall_counter, one instance per input under the macro.
REQ-030 Winner selection and response routing SHALL stay in hci_l2_bank_arbiter.

Verification
REQ-031 Round-robin, all 4 inputs requesting, mem_gnt_i=1 for 8 cycles -> grants 0,1,2,3,0,1,2,3; in_r_valid_o one-hot 1 cycle after each grant.
REQ-032 Fixed priority, inputs 0 and 2 requesting, gnt=1 -> input 0 wins every cycle. With the macro undefined, input 2 is never granted. With the macro defined and MAX_STALL=8, input 2 is granted on cycle 9, then input 0 resumes.
REQ-033 Round-robin, rr_q=3, only input 1 requesting, handshake -> rr_q=2; next grant order from 2 with wrap 3->0.
REQ-034 mem_gnt_i=0 for 3 cycles with input 1 requesting -> mem_id_o=4'b0010 stable, rr_q unchanged, no r_valid; gnt=1 on cycle 4 -> in_r_valid_o[1]=1 on cycle 5, data=mem_r_data_i.
REQ-035 rst_i=1 one cycle after a handshake -> no in_r_valid_o; rr_q=0; counters cleared.
